cmd_fetch: RTL and testbench

Command fetch stage between the processor's instruction-pointer logic and the command memory interface. Drives `instr_ptr` into the command memory banks, accounts for the fixed synchronous read latency, captures the concatenated `cmd_read` word and buffers it in a small FIFO. Commands are presented to the decoder over a valid/ready handshake. Supports start, jump (flush and redirect) and stop.

---
 rtl/cmd_fetch_pkg.sv | 14 +
 rtl/cmd_fetch_if.sv | 31 +++
 rtl/cmd_fetch_fifo.sv | 70 +++++++
 rtl/cmd_fetch.sv | 116 +++++++++++
 tb/tb_cmd_fetch.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_fetch_pkg.sv
// Shared types for the command fetch stage and its decoder.
// Holds the fetch state encoding and the command-width helper.
package cmd_fetch_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } state_e;

   function automatic int cmd_width(input int mem_width, input int mem_to_cmd);
      return mem_width * mem_to_cmd;
   endfunction

endpackage

// File: rtl/cmd_fetch_if.sv
// Command memory read port plus the decoder-facing command stream.
// master = fetch stage, slave = memory/decoder side.
interface cmd_fetch_if #(
   parameter int ADDR_W = 8,
   parameter int CMD_W  = 128
);
   logic [ADDR_W-1:0] instr_ptr;
   logic [CMD_W-1:0]  cmd_read;
   logic              cmd_valid;
   logic [CMD_W-1:0]  cmd_data;
   logic [ADDR_W-1:0] cmd_addr;
   logic              cmd_ready;

   modport master (
      output instr_ptr,
      input  cmd_read,
      output cmd_valid,
      output cmd_data,
      output cmd_addr,
      input  cmd_ready
   );

   modport slave (
      input  instr_ptr,
      output cmd_read,
      input  cmd_valid,
      input  cmd_data,
      input  cmd_addr,
      output cmd_ready
   );
endinterface

// File: rtl/cmd_fetch_fifo.sv
// Show-ahead FIFO with synchronous flush; head visible the cycle after push.
// No internal backpressure: the writer must respect count, pop on empty is ignored.
module cmd_fetch_fifo #(
   parameter int WIDTH = 136,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_dat,
   input  logic                     pop,
   output logic                     empty,
   output logic [WIDTH-1:0]         head_dat,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_push  = push && !flush;
      do_pop   = pop && !flush && (count_q != '0);
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_dat;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      // Flush wins over a same-cycle push or pop.
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         count_d = count_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign empty    = (count_q == '0);
   assign head_dat = mem_q[rd_ptr_q];
   assign count    = count_q;

endmodule

// File: rtl/cmd_fetch.sv
// Command fetch: issues sequential addresses, tracks read latency, buffers commands.
// First command valid 2+L cycles after start/jump; issue stalls on FIFO credit, nothing dropped.
module cmd_fetch
   import cmd_fetch_pkg::*;
#(
   parameter int CMD_ADDR_WIDTH   = 8,
   parameter int MEM_WIDTH        = 32,
   parameter int MEM_TO_CMD       = 4,
   parameter int MEM_READ_LATENCY = 2,
   parameter int FIFO_DEPTH       = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic [CMD_ADDR_WIDTH-1:0] start_addr,
   input  logic                      jump_valid,
   input  logic [CMD_ADDR_WIDTH-1:0] jump_addr,
   input  logic                      stop,
   cmd_fetch_if.master               bus,
   output logic                      busy
);
   localparam int CMD_WIDTH = cmd_width(MEM_WIDTH, MEM_TO_CMD);
   localparam int L         = MEM_READ_LATENCY;
   localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;

   state_e                    state_q, state_d;
   logic [CMD_ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [L-1:0]              tag_vld_q, tag_vld_d;
   logic [CMD_ADDR_WIDTH-1:0] tag_addr_q [L];
   logic [CMD_ADDR_WIDTH-1:0] tag_addr_d [L];

   logic                      flush, issue, capture, pop, fifo_empty;
   logic [CNT_W-1:0]          fifo_count;
   logic [CMD_WIDTH+CMD_ADDR_WIDTH-1:0] head_dat;
   int                        inflight;

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      flush    = stop || ((state_q == FETCH) && (jump_valid || start));
      inflight = 0;
      for (int i = 0; i < L; i++) begin
         inflight += int'(tag_vld_q[i]);
      end
      // Same-cycle pops are not credited, so the FIFO can never overflow at capture.
      issue = (state_q == FETCH) && !flush &&
              ((int'(fifo_count) + inflight) < FIFO_DEPTH);

      if (stop) begin
         state_d = IDLE;
      end else if (start) begin
         state_d = FETCH;
      end

      if (stop) begin
         ptr_d = ptr_q;
      end else if ((state_q == FETCH) && jump_valid) begin
         ptr_d = jump_addr;
      end else if (start) begin
         ptr_d = start_addr;
      end else if (issue) begin
         ptr_d = ptr_q + CMD_ADDR_WIDTH'(1);
      end

      tag_vld_d[0]  = issue;
      tag_addr_d[0] = ptr_q;
      for (int i = 1; i < L; i++) begin
         tag_vld_d[i]  = tag_vld_q[i-1];
         tag_addr_d[i] = tag_addr_q[i-1];
      end
      if (flush) begin
         tag_vld_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         tag_vld_q <= '0;
         for (int i = 0; i < L; i++) begin
            tag_addr_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         tag_vld_q  <= tag_vld_d;
         tag_addr_q <= tag_addr_d;
      end
   end

   assign capture = tag_vld_q[L-1] && !flush;
   assign pop     = bus.cmd_valid && bus.cmd_ready;

   cmd_fetch_fifo #(
      .WIDTH (CMD_WIDTH + CMD_ADDR_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .flush    (flush),
      .push     (capture),
      .push_dat ({tag_addr_q[L-1], bus.cmd_read}),
      .pop      (pop),
      .empty    (fifo_empty),
      .head_dat (head_dat),
      .count    (fifo_count)
   );

   assign bus.instr_ptr = ptr_q;
   assign bus.cmd_valid = !fifo_empty;
   assign bus.cmd_addr  = head_dat[CMD_WIDTH +: CMD_ADDR_WIDTH];
   assign bus.cmd_data  = head_dat[CMD_WIDTH-1:0];
   assign busy          = (state_q == FETCH);

endmodule

// File: tb/tb_cmd_fetch.sv
// Bench for cmd_fetch: memory model with fixed read latency, stream-level reference model,
// directed scenarios with literal expectations, then a randomized control/backpressure phase.
module tb_cmd_fetch;
   import cmd_fetch_pkg::*;

   localparam int A     = 8;
   localparam int L     = 2;
   localparam int DEPTH = 4;
   localparam int CW    = cmd_width(32, 4);

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic         start = 1'b0;
   logic         jump_valid = 1'b0;
   logic         stop = 1'b0;
   logic [A-1:0] start_addr = '0;
   logic [A-1:0] jump_addr = '0;
   logic         busy;

   cmd_fetch_if #(.ADDR_W(A), .CMD_W(CW)) bus ();

   cmd_fetch #(
      .CMD_ADDR_WIDTH   (A),
      .MEM_WIDTH        (32),
      .MEM_TO_CMD       (4),
      .MEM_READ_LATENCY (L),
      .FIFO_DEPTH       (DEPTH)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .start_addr (start_addr),
      .jump_valid (jump_valid),
      .jump_addr  (jump_addr),
      .stop       (stop),
      .bus        (bus),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Command memory contents: distinct per address in every bank.
   function automatic logic [CW-1:0] mem_word(input logic [A-1:0] a);
      logic [31:0] w;
      w = {a, ~a, a ^ 8'h3C, 8'hA5};
      return {w ^ 32'h3333_3333, w ^ 32'h2222_2222, w ^ 32'h1111_1111, w};
   endfunction

   logic [CW-1:0] rd_pipe [L];
   always @(posedge clk) begin
      rd_pipe[0] <= mem_word(bus.instr_ptr);
      for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bus.cmd_read = rd_pipe[L-1];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk_val(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic chk_bit(input string name, input logic act, input logic exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
   endtask

   // Stream-level reference model: which address the decoder must see next and when.
   bit           m_active = 0;
   bit           m_no_pop = 0;
   bit           m_stream = 0;
   bit           m_hold   = 0;
   logic [A-1:0] m_next   = '0;
   logic [A-1:0] m_target = '0;
   int           m_first  = 0;
   int           m_redir  = 0;
   logic [A-1:0] acc_q [$];

   task automatic redirect(input logic [A-1:0] t);
      m_active = 1;
      m_target = t;
      m_next   = t;
      m_first  = cyc + 2 + L;
      m_redir  = cyc;
      m_no_pop = 1;
      m_stream = 0;
      m_hold   = 0;
   endtask

   always @(negedge clk) begin
      int           k;
      logic [A-1:0] e;
      if (!reset_n) begin
         m_active = 0;
         m_no_pop = 0;
         m_stream = 0;
         m_hold   = 0;
      end else begin
         chk_bit("busy", busy, m_active);
         if (bus.cmd_valid) begin
            chk_bit("valid_allowed", m_active && (cyc >= m_first), 1'b1);
            chk_val("cmd_addr", CW'(bus.cmd_addr), CW'(m_next));
            chk_val("cmd_data", bus.cmd_data, mem_word(m_next));
         end
         if (m_active && cyc == m_first) chk_bit("first_valid_time", bus.cmd_valid, 1'b1);
         else if (m_stream) chk_bit("stream_no_gap", bus.cmd_valid, 1'b1);
         if (m_hold) chk_bit("hold_valid", bus.cmd_valid, 1'b1);
         if (m_active && m_no_pop && cyc > m_redir) begin
            k = cyc - m_redir - 1;
            if (k > DEPTH) k = DEPTH;
            e = m_target + A'(k);
            chk_val("instr_ptr_issue", CW'(bus.instr_ptr), CW'(e));
         end

         if (bus.cmd_valid && bus.cmd_ready) begin
            acc_q.push_back(bus.cmd_addr);
            m_next   = m_next + A'(1);
            m_no_pop = 0;
         end
         if (m_active && cyc == m_first) m_stream = 1;
         if (!bus.cmd_ready) m_stream = 0;
         m_hold = bus.cmd_valid && !bus.cmd_ready;
         if (stop) begin
            m_active = 0;
            m_stream = 0;
            m_hold   = 0;
         end else if (m_active && jump_valid) begin
            redirect(jump_addr);
         end else if (start) begin
            redirect(start_addr);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic at_cycle(input int n);
      @(negedge clk);
      while (cyc < n) @(negedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [A-1:0] a, output int c);
      start      = 1'b1;
      start_addr = a;
      c          = cyc;
      step();
      start = 1'b0;
   endtask

   task automatic do_stop();
      step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      repeat (3) step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int           s, n0, x;
      logic [A-1:0] wrap_exp [4];
      wrap_exp[0] = 8'hFE; wrap_exp[1] = 8'hFF; wrap_exp[2] = 8'h00; wrap_exp[3] = 8'h01;

      bus.cmd_ready = 1'b1;
      #1 reset_n = 1'b0;
      #1;
      chk_val("rst_instr_ptr", CW'(bus.instr_ptr), '0);
      chk_bit("rst_cmd_valid", bus.cmd_valid, 1'b0);
      chk_val("rst_cmd_data", bus.cmd_data, '0);
      chk_val("rst_cmd_addr", CW'(bus.cmd_addr), '0);
      chk_bit("rst_busy", busy, 1'b0);
      step();
      step();
      reset_n = 1'b1;
      step();

      // Basic stream from 0x10.
      pulse_start(8'h10, s);
      at_cycle(s + 1);
      chk_val("s1_instr_ptr", CW'(bus.instr_ptr), CW'(8'h10));
      chk_bit("s1_busy", busy, 1'b1);
      at_cycle(s + 3);
      chk_bit("s1_valid_c3", bus.cmd_valid, 1'b0);
      at_cycle(s + 4);
      chk_bit("s1_valid_c4", bus.cmd_valid, 1'b1);
      chk_val("s1_addr_c4", CW'(bus.cmd_addr), CW'(8'h10));
      at_cycle(s + 5);
      chk_val("s1_addr_c5", CW'(bus.cmd_addr), CW'(8'h11));
      at_cycle(s + 6);
      chk_val("s1_addr_c6", CW'(bus.cmd_addr), CW'(8'h12));
      chk_val("s1_data_c6", bus.cmd_data, mem_word(8'h12));
      do_stop();

      // Address wrap-around.
      n0 = acc_q.size();
      pulse_start(8'hFE, s);
      at_cycle(s + 8);
      chk_bit("wrap_count", acc_q.size() >= n0 + 4, 1'b1);
      for (int i = 0; i < 4; i++) chk_val("wrap_addr", CW'(acc_q[n0 + i]), CW'(wrap_exp[i]));
      do_stop();

      // Backpressure: decoder stalled for 20 cycles.
      bus.cmd_ready = 1'b0;
      pulse_start(8'h30, s);
      at_cycle(s + 20);
      chk_val("bp_instr_ptr_frozen", CW'(bus.instr_ptr), CW'(8'h34));
      chk_bit("bp_valid", bus.cmd_valid, 1'b1);
      chk_val("bp_head_addr", CW'(bus.cmd_addr), CW'(8'h30));
      step();
      n0 = acc_q.size();
      bus.cmd_ready = 1'b1;
      at_cycle(s + 30);
      for (int i = 0; i < 6; i++) chk_val("bp_release_addr", CW'(acc_q[n0 + i]), CW'(8'h30 + i));
      do_stop();

      // Jump to 0x40 in cycle 6 with reads in flight.
      pulse_start(8'h50, s);
      at_cycle(s + 5);
      step();
      jump_valid = 1'b1;
      jump_addr  = 8'h40;
      at_cycle(s + 6);
      chk_bit("jump_pre_valid", bus.cmd_valid, 1'b1);
      step();
      jump_valid = 1'b0;
      at_cycle(s + 7);
      chk_bit("jump_valid_c7", bus.cmd_valid, 1'b0);
      chk_val("jump_instr_ptr_c7", CW'(bus.instr_ptr), CW'(8'h40));
      at_cycle(s + 9);
      chk_bit("jump_valid_c9", bus.cmd_valid, 1'b0);
      at_cycle(s + 10);
      chk_bit("jump_valid_c10", bus.cmd_valid, 1'b1);
      chk_val("jump_addr_c10", CW'(bus.cmd_addr), CW'(8'h40));

      // Stop + jump + handshake in the same cycle.
      step();
      step();
      n0         = acc_q.size();
      x          = cyc;
      stop       = 1'b1;
      jump_valid = 1'b1;
      jump_addr  = 8'h77;
      at_cycle(x);
      chk_bit("stop_hs_valid", bus.cmd_valid, 1'b1);
      chk_val("stop_hs_accepted", CW'(acc_q.size()), CW'(n0 + 1));
      step();
      stop       = 1'b0;
      jump_valid = 1'b0;
      at_cycle(x + 1);
      chk_bit("stop_busy", busy, 1'b0);
      chk_bit("stop_valid", bus.cmd_valid, 1'b0);
      repeat (8) step();
      chk_val("stop_no_more_cmds", CW'(acc_q.size()), CW'(n0 + 1));

      // Reset pulse mid-stream, then a fresh start.
      pulse_start(8'h60, s);
      at_cycle(s + 6);
      step();
      #1 reset_n = 1'b0;
      #1;
      chk_val("mrst_instr_ptr", CW'(bus.instr_ptr), '0);
      chk_bit("mrst_cmd_valid", bus.cmd_valid, 1'b0);
      chk_val("mrst_cmd_data", bus.cmd_data, '0);
      chk_val("mrst_cmd_addr", CW'(bus.cmd_addr), '0);
      chk_bit("mrst_busy", busy, 1'b0);
      step();
      reset_n = 1'b1;
      step();
      pulse_start(8'h20, s);
      at_cycle(s + 3);
      chk_bit("post_rst_valid_c3", bus.cmd_valid, 1'b0);
      at_cycle(s + 4);
      chk_bit("post_rst_valid_c4", bus.cmd_valid, 1'b1);
      chk_val("post_rst_addr_c4", CW'(bus.cmd_addr), CW'(8'h20));
      do_stop();

      // Randomized control and backpressure.
      for (int i = 0; i < 3000; i++) begin
         bus.cmd_ready = ($urandom % 10) < 7;
         stop          = ($urandom % 100) < 1;
         jump_valid    = ($urandom % 100) < 3;
         jump_addr     = A'($urandom);
         start         = busy ? (($urandom % 100) < 2) : (($urandom % 100) < 15);
         start_addr    = A'($urandom);
         step();
      end
      start      = 1'b0;
      jump_valid = 1'b0;
      stop       = 1'b0;
      bus.cmd_ready = 1'b1;
      repeat (10) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
